// File: rtl/layer_4_stream_scheduler.sv
// layer_4_stream_scheduler: frames a pixel stream into a parallel conv bank, flushes its line buffers and counts results
module layer_4_stream_scheduler #(
  parameter int DATA_WIDTH   = 1024,
  parameter int IMG_SIZE     = 104,
  parameter int FLUSH_CYCLES = 210,
  parameter int CNT_W        = 14
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] conv_data,
  output logic                  conv_valid,
  input  logic                  bank_valid,
  output logic [CNT_W-1:0]      row,
  output logic [CNT_W-1:0]      col,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, WAIT_OUT, DONE} state_t;
  localparam logic [CNT_W-1:0] N_PIX      = CNT_W'(IMG_SIZE * IMG_SIZE);
  localparam logic [CNT_W-1:0] LAST_PIX   = CNT_W'(IMG_SIZE * IMG_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(IMG_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(FLUSH_CYCLES - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] in_cnt, out_cnt, flush_cnt;
  logic accept, out_full, counting;
  assign in_ready = state == STREAM;
  assign accept   = in_ready & in_valid;
  assign out_full = out_cnt == N_PIX;
  assign counting = state inside {STREAM, FLUSH, WAIT_OUT};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? STREAM : IDLE;
      STREAM:   state_nx = (accept && in_cnt == LAST_PIX) ? FLUSH : STREAM;
      FLUSH:    state_nx = flush_cnt == LAST_FLUSH ? WAIT_OUT : FLUSH;
      WAIT_OUT: state_nx = out_full ? DONE : WAIT_OUT;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      flush_cnt  <= '0;
      conv_data  <= '0;
      conv_valid <= 1'b0;
      row        <= '0;
      col        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      conv_valid <= accept || state == FLUSH;
      flush_cnt  <= state == FLUSH ? flush_cnt + 1'b1 : '0;
      done       <= state == DONE;
      err        <= err | (bank_valid & (state == IDLE || state == DONE || out_full)) | (start & busy);
      if (accept) conv_data <= in_data;
      else if (state == FLUSH) conv_data <= '0;
      // row/col describe the pixel being forwarded, so the first pixel keeps 0/0
      if (accept) begin
        in_cnt <= in_cnt + 1'b1;
        if (in_cnt != '0) begin
          col <= col == LAST_IDX ? '0 : col + 1'b1;
          if (col == LAST_IDX) row <= row + 1'b1;
        end
      end
      if (bank_valid && counting && !out_full) out_cnt <= out_cnt + 1'b1;
      if (state == DONE) busy <= 1'b0;
      if (state == IDLE && start) begin
        busy    <= 1'b1;
        in_cnt  <= '0;
        out_cnt <= '0;
        row     <= '0;
        col     <= '0;
      end
    end
  end
endmodule
